// File: rtl/tft_bus_arbiter.sv
// Round-robin arbiter that lends the single tft_spi transmitter to one requester per job,
// using each requester's enable/busy handshake; requester 0 (init) can be forced to go first.
module tft_bus_arbiter #(
    parameter int N          = 3,
    parameter bit INIT_FIRST = 1'b1,
    localparam int W         = (N > 1) ? $clog2(N) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_busy_in,
    input  logic [8*N-1:0] i_data_in,
    input  logic [N-1:0]   i_dc_in,
    input  logic [N-1:0]   i_transmit_in,
    input  logic           i_spi_busy,
    output logic [N-1:0]   o_enable,
    output logic [7:0]     o_spi_data,
    output logic           o_spi_dc,
    output logic           o_spi_transmit,
    output logic [W-1:0]   o_grant_id,
    output logic           o_idle,
    output logic           o_init_done,
    output logic [1:0]     o_state
);

    // Handshake: the granted requester sees enable held from grant until the job ends;
    // it raises busy to claim the job and drops it when done. The job only ends once
    // both its busy and spi_busy are low, so the last byte always finishes shifting.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_enable;
    logic [W-1:0]   r_grant_id;
    logic [W-1:0]   r_last;
    logic           r_idle;
    logic           r_init_done;

    logic [N-1:0]   w_elig;
    logic           w_found;
    logic [W-1:0]   w_pick;
    logic [W-1:0]   w_sel;
    int             w_idx;
    logic           w_gbusy;
    logic           w_greq;
    logic [7:0]     w_data;
    logic           w_dc;
    logic           w_tx;

    // Scan last+1, last+2, ... so the most recently served requester is considered last.
    always_comb begin
        w_elig  = i_req & (r_init_done ? {N{1'b1}} : N'(1));
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        w_sel   = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = (int'(r_last) + i) % N;
            w_sel = W'(w_idx);
            if (!w_found && w_elig[w_sel]) begin
                w_found = 1'b1;
                w_pick  = w_sel;
            end
        end
    end

    always_comb begin
        w_gbusy = 1'b0;
        w_greq  = 1'b0;
        w_data  = 8'h00;
        w_dc    = 1'b0;
        w_tx    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (W'(k) == r_grant_id) begin
                w_gbusy = i_busy_in[k];
                w_greq  = i_req[k];
                if (r_enable[k]) begin
                    w_data = i_data_in[8*k +: 8];
                    w_dc   = i_dc_in[k];
                    w_tx   = i_transmit_in[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_enable    <= '0;
            r_grant_id  <= '0;
            r_last      <= W'(N - 1);
            r_idle      <= 1'b1;
            r_init_done <= !INIT_FIRST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_enable   <= N'(1) << w_pick;
                        r_idle     <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_gbusy)
                        r_state <= S_RUN;
                    else if (!w_greq)
                        r_state <= S_RELEASE;
                end
                S_RUN: begin
                    if (!w_gbusy && !i_spi_busy)
                        r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Enable drops here, so the next grant is separated by one all-zero cycle.
                    r_enable <= '0;
                    r_last   <= r_grant_id;
                    if (r_grant_id == '0)
                        r_init_done <= 1'b1;
                    r_idle   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_enable       = r_enable;
    assign o_grant_id     = r_grant_id;
    assign o_idle         = r_idle;
    assign o_init_done    = r_init_done;
    assign o_state        = r_state;
    assign o_spi_data     = w_data;
    assign o_spi_dc       = w_dc;
    assign o_spi_transmit = w_tx;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Bench for tft_bus_arbiter (N=3, INIT_FIRST=1): directed jobs, grant/SPI scoreboard.
module tb_tft_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  busy_in;
  logic [23:0] data_in;
  logic [2:0]  dc_in;
  logic [2:0]  tx_in;
  logic        spi_busy;
  logic [2:0]  o_enable;
  logic [7:0]  o_spi_data;
  logic        o_spi_dc;
  logic        o_spi_transmit;
  logic [1:0]  o_grant_id;
  logic        o_idle;
  logic        o_init_done;
  logic [1:0]  o_state;

  logic [2:0]  exp_q[$];
  logic [8:0]  spi_q[$];
  int          n_pass;
  int          n_total;
  logic [2:0]  mon_prev_en;

  tft_bus_arbiter #(.N(3), .INIT_FIRST(1'b1)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req(req),
    .i_busy_in(busy_in),
    .i_data_in(data_in),
    .i_dc_in(dc_in),
    .i_transmit_in(tx_in),
    .i_spi_busy(spi_busy),
    .o_enable(o_enable),
    .o_spi_data(o_spi_data),
    .o_spi_dc(o_spi_dc),
    .o_spi_transmit(o_spi_transmit),
    .o_grant_id(o_grant_id),
    .o_idle(o_idle),
    .o_init_done(o_init_done),
    .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic report();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  initial begin
    #200000;
    n_total++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
  end

  // monitor: each new grant and each SPI strobe is popped against the scoreboard
  initial begin
    logic [2:0] e;
    logic [8:0] s;
    mon_prev_en = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (o_enable != 3'b000 && mon_prev_en == 3'b000) begin
          if (exp_q.size() == 0) chk("grant_unexpected", {29'd0, o_enable}, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("grant_order", {29'd0, o_enable}, {29'd0, e});
          end
        end
        if (o_spi_transmit) begin
          if (spi_q.size() == 0) chk("spi_unexpected", {23'd0, o_spi_dc, o_spi_data}, 32'd0);
          else begin
            s = spi_q.pop_front();
            chk("spi_byte", {23'd0, o_spi_dc, o_spi_data}, {23'd0, s});
          end
        end
      end
      mon_prev_en = o_enable;
    end
  end

  // driver tasks
  task automatic wait_grant(output int k, output int gap);
    gap = 0;
    while (o_enable == 3'b000 && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    if (o_enable == 3'b000) begin
      n_total++;
      $display("FAIL grant_timeout: enable=0 required nonzero");
      report();
    end
    k = 0;
    for (int i = 0; i < 3; i++) if (o_enable[i]) k = i;
  endtask

  task automatic run_busy(input int k, input int len);
    busy_in[k] = 1'b1;
    repeat (len) @(negedge clk);
  endtask

  task automatic end_job(input int k, input int tail, input bit drop);
    busy_in[k] = 1'b0;
    spi_busy = (tail > 0);
    if (drop) req[k] = 1'b0;
    for (int t = 0; t < tail; t++) begin
      @(negedge clk);
      chk("spi_tail_hold", {31'd0, o_enable[k]}, 32'd1);
      if (t == tail - 1) spi_busy = 1'b0;
    end
    @(negedge clk);
    chk("release_state", {30'd0, o_state}, 32'd3);
    @(negedge clk);
    chk("released_enable", {29'd0, o_enable}, 32'd0);
    chk("released_idle", {31'd0, o_idle}, 32'd1);
  endtask

  initial begin
    int k;
    int gap;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    req = '0;
    busy_in = '0;
    data_in = '0;
    dc_in = '0;
    tx_in = '0;
    spi_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_enable", {29'd0, o_enable}, 32'd0);
    chk("rst_idle", {31'd0, o_idle}, 32'd1);
    chk("rst_init_done", {31'd0, o_init_done}, 32'd0);
    chk("rst_grant_id", {30'd0, o_grant_id}, 32'd0);
    chk("rst_spi", {22'd0, o_spi_transmit, o_spi_dc, o_spi_data}, 32'd0);
    rst = 1'b0;

    // init first: all request, only requester 0 is served
    req = 3'b111;
    exp_q.push_back(3'b001);
    @(negedge clk);
    chk("init_latency", {29'd0, o_enable}, 32'd1);
    chk("init_not_idle", {31'd0, o_idle}, 32'd0);
    wait_grant(k, gap);
    run_busy(0, 6);
    chk("init_exclusive", {29'd0, o_enable}, 32'd1);
    chk("init_pending", {31'd0, o_init_done}, 32'd0);
    end_job(0, 0, 1'b1);
    chk("init_done_set", {31'd0, o_init_done}, 32'd1);

    // continuous requesters 1 and 2: alternate with one-cycle gaps
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    for (int j = 0; j < 4; j++) begin
      wait_grant(k, gap);
      chk("rr_gap", gap, 32'd1);
      run_busy(k, 20);
      end_job(k, 0, 1'b0);
    end
    req = 3'b000;

    // requester 2 alone, spi still shifting after its busy drops
    repeat (2) @(negedge clk);
    req = 3'b100;
    exp_q.push_back(3'b100);
    wait_grant(k, gap);
    run_busy(2, 5);
    end_job(2, 7, 1'b1);

    // mux isolation: requester 2 strobes A5 while requester 1 owns the bus
    req = 3'b010;
    exp_q.push_back(3'b010);
    wait_grant(k, gap);
    busy_in[1] = 1'b1;
    data_in = {8'hA5, 8'h3C, 8'h00};
    dc_in = 3'b110;
    tx_in = 3'b110;
    spi_q.push_back({1'b1, 8'h3C});
    @(negedge clk);
    tx_in = 3'b100;
    @(negedge clk);
    chk("iso_transmit", {31'd0, o_spi_transmit}, 32'd0);
    chk("iso_data", {24'd0, o_spi_data}, 32'h3C);
    tx_in = 3'b000;
    @(negedge clk);
    end_job(1, 0, 1'b1);
    data_in = '0;
    dc_in = '0;
    chk("idle_spi_zero", {23'd0, o_spi_dc, o_spi_data}, 32'd0);

    // abort in START: requester 1 withdraws, requester 0 takes over
    req = 3'b010;
    exp_q.push_back(3'b010);
    wait_grant(k, gap);
    req = 3'b001;
    exp_q.push_back(3'b001);
    @(negedge clk);
    chk("abort_release", {30'd0, o_state}, 32'd3);
    @(negedge clk);
    chk("abort_dropped", {29'd0, o_enable}, 32'd0);
    wait_grant(k, gap);
    chk("abort_next", k, 32'd0);
    chk("abort_init_done", {31'd0, o_init_done}, 32'd1);
    run_busy(0, 3);
    end_job(0, 0, 1'b1);

    // reset mid-RUN
    req = 3'b111;
    exp_q.push_back(3'b010);
    wait_grant(k, gap);
    run_busy(1, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_enable", {29'd0, o_enable}, 32'd0);
    chk("midrst_spi", {22'd0, o_spi_transmit, o_spi_dc, o_spi_data}, 32'd0);
    chk("midrst_idle", {31'd0, o_idle}, 32'd1);
    chk("midrst_init_done", {31'd0, o_init_done}, 32'd0);
    chk("midrst_state", {30'd0, o_state}, 32'd0);
    busy_in = '0;
    rst = 1'b0;
    exp_q.push_back(3'b001);
    wait_grant(k, gap);
    chk("midrst_regrant", k, 32'd0);
    run_busy(0, 3);
    end_job(0, 0, 1'b1);
    req = 3'b000;
    chk("midrst_init_again", {31'd0, o_init_done}, 32'd1);

    repeat (3) @(negedge clk);
    chk("grant_q_drained", exp_q.size(), 32'd0);
    chk("spi_q_drained", spi_q.size(), 32'd0);
    report();
  end

endmodule
